// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: initiator-side data-memory controller for the MEM stage.
// Loads issue a single doubleword read. Stores do a read-modify-write: they
// read the partner doubleword, merge it with the store data and write the
// aligned 128-bit word.
// Optional build macro DMEM_MISALIGN_CHK_EN: when defined, a request whose
// low three address bits are not zero skips the memory and responds with
// resp_err=1. When undefined, those bits are masked and resp_err stays 0.
module dmem_access_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [2*DATA_W-1:0]   mem_write_data_word,
  input  logic [DATA_W-1:0]     mem_read_data
);

  typedef enum logic [2:0] {
    IDLE, LD_ISSUE, LD_WAIT, ST_RD, ST_RD_WAIT, ST_WR, RESP
  } state_t;

  localparam logic [3:0]        LAT       = 4'(RD_LAT);
  localparam logic [ADDR_W-1:0] DW_MASK   = ~ADDR_W'(7);
  localparam logic [ADDR_W-1:0] QW_MASK   = ~ADDR_W'(15);
  localparam logic [ADDR_W-1:0] HALF_BIT  = ADDR_W'(8);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   partner_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [3:0]          cnt_q;

  logic                accept;
  logic                misalign;
  logic                rd_capture;

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign = (req_addr[2:0] != 3'b000);
`else
  assign misalign = 1'b0;
`endif

  // State register; async reset drops any in-flight transaction at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and all request/memory/response outputs
  always_comb begin
    state_nx            = state;
    req_ready           = 1'b0;
    resp_valid          = 1'b0;
    mem_read_en         = 1'b0;
    mem_write_en        = 1'b0;
    mem_address         = '0;
    mem_write_data_word = '0;
    accept              = 1'b0;
    rd_capture          = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (misalign)    state_nx = RESP;
          else if (req_we) state_nx = ST_RD;
          else             state_nx = LD_ISSUE;
        end
      end
      LD_ISSUE: begin
        mem_read_en = 1'b1;
        mem_address = addr_q;
        if (LAT == 4'd0) begin
          rd_capture = 1'b1;
          state_nx   = RESP;
        end else begin
          state_nx   = LD_WAIT;
        end
      end
      LD_WAIT: begin
        if (cnt_q == LAT) begin
          rd_capture = 1'b1;
          state_nx   = RESP;
        end
      end
      ST_RD: begin
        mem_read_en = 1'b1;
        mem_address = addr_q ^ HALF_BIT;
        if (LAT == 4'd0) begin
          rd_capture = 1'b1;
          state_nx   = ST_WR;
        end else begin
          state_nx   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == LAT) begin
          rd_capture = 1'b1;
          state_nx   = ST_WR;
        end
      end
      ST_WR: begin
        mem_write_en = 1'b1;
        mem_address  = addr_q & QW_MASK;
        // Store data lands in the half selected by address bit 3
        if (addr_q[3]) mem_write_data_word = {wdata_q, partner_q};
        else           mem_write_data_word = {partner_q, wdata_q};
        state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_en     = mem_read_en | mem_write_en;
  assign resp_rdata = (state == RESP) ? rdata_q : '0;
  assign resp_err   = (state == RESP) & err_q;

  // Request latch, read-latency counter and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      partner_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr & DW_MASK;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= misalign;
        cnt_q   <= '0;
      end
      if (state == LD_ISSUE || state == ST_RD)
        cnt_q <= 4'd1;
      else if (state == LD_WAIT || state == ST_RD_WAIT)
        cnt_q <= cnt_q + 4'd1;
      if (rd_capture) begin
        if (state == LD_ISSUE || state == LD_WAIT) rdata_q   <= mem_read_data;
        else                                       partner_q <= mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl with RD_LAT=1 and a 256-byte memory model.
module tb_dmem_access_ctrl;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int RD_LAT = 1;
`ifdef DMEM_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic                req_we = 1'b0;
  logic [ADDR_W-1:0]   req_addr = '0;
  logic [DATA_W-1:0]   req_wdata = '0;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;
  logic                mem_en;
  logic                mem_read_en;
  logic                mem_write_en;
  logic [ADDR_W-1:0]   mem_address;
  logic [2*DATA_W-1:0] mem_write_data_word;
  logic [DATA_W-1:0]   mem_read_data;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_address(mem_address), .mem_write_data_word(mem_write_data_word),
    .mem_read_data(mem_read_data)
  );

  // Memory environment: one-cycle read latency, 128-bit aligned writes
  logic [63:0] env_mem [0:31] = '{default: 64'h0};
  logic [63:0] rd_pipe = 64'h0;
  always @(posedge clk) begin
    if (mem_read_en) rd_pipe <= env_mem[mem_address[7:3]];
    if (mem_write_en) begin
      env_mem[{mem_address[7:4], 1'b0}] <= mem_write_data_word[63:0];
      env_mem[{mem_address[7:4], 1'b1}] <= mem_write_data_word[127:64];
    end
  end
  assign mem_read_data = rd_pipe;

  // Reference view of memory contents, updated only from the store rules
  logic [63:0] ref_mem [0:31] = '{default: 64'h0};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag, input logic exp_ready);
    chk({tag, "_strobes"}, 128'({mem_en, mem_read_en, mem_write_en}), 128'(0));
    chk({tag, "_maddr"}, 128'(mem_address), 128'(0));
    chk({tag, "_mwdata"}, mem_write_data_word, 128'(0));
    chk({tag, "_req_ready"}, 128'(req_ready), 128'(exp_ready));
  endtask

  // One complete transaction starting in an idle cycle; bp = cycles of resp_ready=0
  task automatic do_txn(input string tag, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input int bp);
    logic [63:0]  a;
    logic [63:0]  partner;
    logic [63:0]  exp_rd;
    logic [127:0] exp_word;
    logic         exp_err;
    a       = addr & ~64'h7;
    partner = a ^ 64'h8;
    exp_err = 1'b0;
    exp_rd  = 64'h0;
    // cycle A: present request
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    chk({tag, "_ready_A"}, 128'(req_ready), 128'(1));
    tick();
    req_valid = 1'b0; req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    req_we = 1'(($urandom));
    if (MIS_EN && addr[2:0] != 3'b000) begin
      exp_err = 1'b1;
    end else if (!we) begin
      chk({tag, "_ld_strobes"}, 128'({mem_en, mem_read_en, mem_write_en}), 128'(3'b110));
      chk({tag, "_ld_addr"}, 128'(mem_address), 128'(a));
      chk({tag, "_ld_resp_early"}, 128'(resp_valid), 128'(0));
      tick();
      chk_quiet({tag, "_ld_wait"}, 1'b0);
      chk({tag, "_ld_wait_resp"}, 128'(resp_valid), 128'(0));
      tick();
      exp_rd = ref_mem[a[7:3]];
    end else begin
      chk({tag, "_st_rd_strobes"}, 128'({mem_en, mem_read_en, mem_write_en}), 128'(3'b110));
      chk({tag, "_st_rd_addr"}, 128'(mem_address), 128'(partner));
      tick();
      chk_quiet({tag, "_st_wait"}, 1'b0);
      tick();
      exp_word = a[3] ? {wdata, ref_mem[partner[7:3]]} : {ref_mem[partner[7:3]], wdata};
      chk({tag, "_st_wr_strobes"}, 128'({mem_en, mem_read_en, mem_write_en}), 128'(3'b101));
      chk({tag, "_st_wr_addr"}, 128'(mem_address), 128'(a & ~64'hF));
      chk({tag, "_st_wr_word"}, mem_write_data_word, exp_word);
      chk({tag, "_st_wr_resp"}, 128'(resp_valid), 128'(0));
      ref_mem[a[7:3]] = wdata;
      tick();
    end
    // response phase, with stray requests that must be ignored
    for (int i = 0; i <= bp; i++) begin
      resp_ready = (i == bp);
      req_valid  = 1'(($urandom));
      chk({tag, "_resp_valid"}, 128'(resp_valid), 128'(1));
      chk({tag, "_resp_rdata"}, 128'(resp_rdata), 128'(exp_rd));
      chk({tag, "_resp_err"}, 128'(resp_err), 128'(exp_err));
      chk_quiet({tag, "_resp"}, 1'b0);
      tick();
    end
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk({tag, "_after_resp"}, 128'(resp_valid), 128'(0));
    chk_quiet({tag, "_idle"}, 1'b1);
  endtask

  initial begin
    logic [63:0] r_addr;
    logic [63:0] r_data;
    // reset state
    tick();
    chk_quiet("rst", 1'b1);
    chk("rst_resp", 128'({resp_valid, resp_err, resp_rdata}), 128'(0));
    rst_n = 1'b1;
    tick();
    chk_quiet("post_rst", 1'b1);

    // load after store of a known value
    do_txn("st40", 1'b1, 64'h40, 64'hDEADBEEF, 0);
    do_txn("ld40", 1'b0, 64'h40, 64'h0, 0);
    // store into the high half keeps the low partner
    do_txn("st20", 1'b1, 64'h20, 64'h1111, 0);
    do_txn("st28", 1'b1, 64'h28, 64'hA3, 0);
    do_txn("ld20", 1'b0, 64'h20, 64'h0, 0);
    // store into the low half, then read it back
    do_txn("st38", 1'b1, 64'h38, 64'h7777_0000_1234_5678, 0);
    do_txn("st30", 1'b1, 64'h30, 64'h55, 1);
    do_txn("ld30", 1'b0, 64'h30, 64'h0, 0);
    do_txn("ld38", 1'b0, 64'h38, 64'h0, 2);
    // long response backpressure
    do_txn("bp5", 1'b0, 64'h28, 64'h0, 5);
    // unaligned address: masked, or flagged when the check is built in
    do_txn("mis43", 1'b0, 64'h43, 64'h0, 0);
    do_txn("mis_st", 1'b1, 64'h4D, 64'hCAFE, 1);
    do_txn("ld48", 1'b0, 64'h48, 64'h0, 0);

    // reset in the middle of a store: write must never happen
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h48; req_wdata = 64'hBAD0BAD0;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst", 1'b1);
    chk("midrst_resp", 128'(resp_valid), 128'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_quiet("midrst_after", 1'b1);
      chk("midrst_after_resp", 128'(resp_valid), 128'(0));
      tick();
    end
    do_txn("ld48_after_rst", 1'b0, 64'h48, 64'h0, 0);

    // randomized traffic over the small memory window
    for (int n = 0; n < 60; n++) begin
      r_addr = 64'($urandom_range(0, 255));
      r_data = {$urandom, $urandom};
      do_txn("rand", 1'(($urandom)), r_addr, r_data, $urandom_range(0, 3));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator-side controller for the data memory: the MEM-stage pipeline hands it one 64-bit load or store, and it drives the datamem request port.
- Stores are 64-bit, but the memory's write port is 128-bit. The block therefore performs a read-modify-write: it reads the partner doubleword, merges, then writes the aligned 128-bit word.
- Valid/ready handshake on both the request and the response side.

Parameters:
- ADDR_W, 64, byte address width.
- DATA_W, 64, pipeline data width; memory write word is 2*DATA_W.
- RD_LAT, 1, memory read latency in cycles: mem_read_data is valid RD_LAT cycles after the mem_read_en cycle. Legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1=store, 0=load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  pipeline accepts response.
- resp_rdata  out  DATA_W  load data; 0 for stores.
- resp_err  out  1  misaligned-access error (optional feature only).
- mem_en  out  1  memory enable.
- mem_read_en  out  1  memory read strobe.
- mem_write_en  out  1  memory write strobe.
- mem_address  out  ADDR_W  memory byte address.
- mem_write_data_word  out  2*DATA_W  128-bit write word.
- mem_read_data  in  DATA_W  memory read data.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output 0 except req_ready=1. Internal address, data, partner and counter registers cleared.
- Reset mid-operation: strobes deassert immediately; the transaction is dropped; no response is issued.
- FSM states: IDLE, LD_ISSUE, LD_WAIT, ST_RD, ST_RD_WAIT, ST_WR, RESP.
- req_ready=1 only in IDLE. A request is accepted on req_valid&req_ready in cycle A; addr, we and wdata are latched.
- Address: low 3 bits are forced to 0 (doubleword aligned). Partner address = addr ^ 8. Write address = addr & ~15.
- Strobes are single-cycle. mem_en=1 exactly in cycles where mem_read_en or mem_write_en is 1. mem_read_en and mem_write_en are never both 1.
- Load path:
  - LD_ISSUE (cycle A+1): mem_read_en=1, mem_address=addr.
  - LD_WAIT: a counter counts RD_LAT cycles.
  - mem_read_data is captured at the end of cycle A+1+RD_LAT. For RD_LAT=0 it is captured in the LD_ISSUE cycle itself and LD_WAIT is skipped.
  - resp_valid=1 from cycle A+2+RD_LAT.
- Store path:
  - ST_RD (A+1): mem_read_en=1, mem_address=partner.
  - ST_RD_WAIT: the partner doubleword is captured at the end of A+1+RD_LAT.
  - ST_WR (A+2+RD_LAT): mem_write_en=1, mem_address=addr&~15.
  - mem_write_data_word = {hi,lo}. If addr[3]=0: lo=wdata, hi=partner. If addr[3]=1: lo=partner, hi=wdata.
  - resp_valid from A+3+RD_LAT; resp_rdata=0.
- RESP: resp_valid, resp_rdata and resp_err are held stable until resp_ready. On handshake go to IDLE, so the next accept is one cycle later at the earliest.
- mem_address and mem_write_data_word are 0 when no strobe is active.
- Simultaneous req_valid during RESP is ignored (req_ready=0); the request must stay asserted.

Optional Feature:
- Macro: DMEM_MISALIGN_CHK_EN.
- Defined: a request with req_addr[2:0]!=0 causes no memory access. The FSM goes IDLE->RESP directly: resp_valid at A+1, resp_err=1, resp_rdata=0.
- Undefined: low 3 bits are silently masked, and resp_err is tied to 0.

Test Plan:
- Reset: rst_n=0 mid-store (in ST_RD_WAIT) -> all strobes 0 that cycle, req_ready=1; after release, no resp_valid appears.
- Load, RD_LAT=1: accept addr=0x40 at A; memory returns 0xDEAD_BEEF at A+2 -> mem_read_en@A+1 with address 0x40, resp_valid@A+3, resp_rdata=0xDEADBEEF.
- Store hi half: memory holds 0x1111 at 0x20; store wdata=0xA3 to 0x28 -> read of 0x20, then write at 0x20 with mem_write_data_word={0xA3,0x1111}, resp_valid, resp_rdata=0.
- Store lo half then load: store 0x55 to 0x30 -> write word {mem[0x38],0x55}; a following load of 0x30 returns 0x55.
- Backpressure: resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0, no memory strobes; release -> IDLE next cycle.
- With DMEM_MISALIGN_CHK_EN: load of 0x43 -> no mem_en, resp_valid@A+1 with resp_err=1. Without the macro -> load of 0x40 is performed.
